// File: rtl/timer_regs_if.sv
// CPU-side bus bundle for the FF04-FF07 timer block: decoder select, strobes, data and timer outputs.
interface timer_regs_if;
  logic       ff04_ff07;
  logic [1:0] a;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_timer;
  logic       div_apu;

  modport master (
    output ff04_ff07, a, cpu_wr, cpu_rd, d_in,
    input  d_out, d_oe, int_timer, div_apu
  );

  modport slave (
    input  ff04_ff07, a, cpu_wr, cpu_rd, d_in,
    output d_out, d_oe, int_timer, div_apu
  );
endinterface

// File: rtl/timer_regs.sv
// DMG timer registers DIV/TIMA/TMA/TAC at FF04-FF07 with delayed TMA reload and timer interrupt.
// Define TIMER_DIV_GLITCH_EN to also count tap falling edges caused by DIV and TAC writes.
module timer_regs #(
  parameter int DIV_WIDTH    = 16,
  parameter int RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  timer_regs_if.slave bus
);

  localparam int CNT_W = $clog2(RELOAD_DELAY + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t RELOAD_INIT = cnt_t'(RELOAD_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_RELOAD
  } state_t;

  logic [DIV_WIDTH-1:0] r_divCnt;
  logic [7:0]           r_tima;
  logic [7:0]           r_tma;
  logic [2:0]           r_tac;
  state_t               r_state;
  cnt_t                 r_cnt;
  logic                 r_intTimer;

  state_t               w_stateNext;
  cnt_t                 w_cntNext;
  logic [7:0]           w_timaNext;
  logic [7:0]           w_tmaNext;
  logic                 w_intNext;
  logic                 w_inc;
  logic                 w_wr;
  logic                 w_wrDiv;
  logic                 w_wrTima;
  logic                 w_wrTma;
  logic                 w_wrTac;

  assign w_wr     = bus.ff04_ff07 && bus.cpu_wr;
  assign w_wrDiv  = w_wr && (bus.a == 2'd0);
  assign w_wrTima = w_wr && (bus.a == 2'd1);
  assign w_wrTma  = w_wr && (bus.a == 2'd2);
  assign w_wrTac  = w_wr && (bus.a == 2'd3);

`ifdef TIMER_DIV_GLITCH_EN
  logic w_tap;
  logic w_tickSig;
  logic r_tickQ;

  always_comb begin
    w_tap = 1'b0;
    case (r_tac[1:0])
      2'b00:   w_tap = r_divCnt[9];
      2'b01:   w_tap = r_divCnt[3];
      2'b10:   w_tap = r_divCnt[5];
      default: w_tap = r_divCnt[7];
    endcase
  end

  assign w_tickSig = w_tap && r_tac[2];

  always_ff @(posedge clk) begin
    if (reset) r_tickQ <= 1'b0;
    else       r_tickQ <= w_tickSig;
  end

  assign w_inc = r_tickQ && !w_tickSig;
`else
  // The tap bit fell through a count exactly when every bit up to it carried to zero.
  logic w_carryOut;
  logic r_enQ;
  logic r_divWrQ;

  always_comb begin
    w_carryOut = 1'b0;
    case (r_tac[1:0])
      2'b00:   w_carryOut = (r_divCnt[9:0] == 10'd0);
      2'b01:   w_carryOut = (r_divCnt[3:0] == 4'd0);
      2'b10:   w_carryOut = (r_divCnt[5:0] == 6'd0);
      default: w_carryOut = (r_divCnt[7:0] == 8'd0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enQ    <= 1'b0;
      r_divWrQ <= 1'b0;
    end else begin
      r_enQ    <= r_tac[2];
      r_divWrQ <= w_wrDiv;
    end
  end

  assign w_inc = w_carryOut && r_tac[2] && r_enQ && !r_divWrQ;
`endif

  // RELOAD is the last pending clk; TIMA takes TMA (or a same-clk TMA write) on its closing edge.
  always_comb begin
    w_timaNext  = r_tima;
    w_tmaNext   = w_wrTma ? bus.d_in : r_tma;
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_intNext   = 1'b0;
    case (r_state)
      ST_RELOAD: begin
        w_timaNext  = w_tmaNext;
        w_intNext   = 1'b1;
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
      ST_PENDING: begin
        if (w_wrTima) begin
          w_timaNext  = bus.d_in;
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else begin
          if (w_inc) w_timaNext = r_tima + 8'd1;
          w_cntNext = r_cnt - cnt_t'(1);
          if (r_cnt == cnt_t'(2)) w_stateNext = ST_RELOAD;
        end
      end
      default: begin
        if (w_wrTima) begin
          w_timaNext = bus.d_in;
        end else if (w_inc) begin
          if (r_tima == 8'hFF) begin
            w_timaNext  = 8'h00;
            w_cntNext   = RELOAD_INIT;
            w_stateNext = (RELOAD_DELAY == 1) ? ST_RELOAD : ST_PENDING;
          end else begin
            w_timaNext = r_tima + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tima     <= 8'h00;
      r_tma      <= 8'h00;
      r_tac      <= 3'b000;
      r_divCnt   <= '0;
      r_intTimer <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_tima     <= w_timaNext;
      r_tma      <= w_tmaNext;
      r_tac      <= w_wrTac ? bus.d_in[2:0] : r_tac;
      r_divCnt   <= w_wrDiv ? '0 : r_divCnt + DIV_WIDTH'(1);
      r_intTimer <= w_intNext;
    end
  end

  assign bus.d_oe      = bus.ff04_ff07 && bus.cpu_rd;
  assign bus.int_timer = r_intTimer;
  assign bus.div_apu   = r_divCnt[12];

  always_comb begin
    bus.d_out = 8'h00;
    if (bus.d_oe) begin
      case (bus.a)
        2'd0:    bus.d_out = r_divCnt[DIV_WIDTH-1 -: 8];
        2'd1:    bus.d_out = r_tima;
        2'd2:    bus.d_out = r_tma;
        default: bus.d_out = {5'b11111, r_tac};
      endcase
    end
  end

endmodule

// File: tb/tb_timer_regs.sv
// Scoreboard bench for timer_regs: a cycle-level reference model predicts reads and interrupt pulses.
module tb_timer_regs;

  localparam int RELOAD_DELAY = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  timer_regs_if bus ();

  timer_regs #(
    .DIV_WIDTH   (16),
    .RELOAD_DELAY(RELOAD_DELAY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int intSeen     = 0;
  int edgeCnt     = 0;

  // Reference model state: values the registers hold during the current clk.
  logic [15:0] mDiv = '0;
  logic [15:0] mPrevDiv = '0;
  logic [7:0]  mTima = '0;
  logic [7:0]  mTma = '0;
  logic [2:0]  mTac = '0;
  logic [2:0]  mPrevTac = '0;
  logic        mPrevDivWr = 1'b0;
  bit          mPending = 1'b0;
  int          mReloadAt = 0;

  logic [7:0] rdQ[$];
  int         intQ[$];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic tapOf(input logic [15:0] dv, input logic [2:0] tc);
    case (tc[1:0])
      2'b00:   return dv[9];
      2'b01:   return dv[3];
      2'b10:   return dv[5];
      default: return dv[7];
    endcase
  endfunction

  function automatic logic [7:0] modelRead(input logic [1:0] addr);
    case (addr)
      2'd0:    return mDiv[15:8];
      2'd1:    return mTima;
      2'd2:    return mTma;
      default: return {5'b11111, mTac};
    endcase
  endfunction

  // The model reloads by timestamp: the reload edge is RELOAD_DELAY edges after the overflow edge.
  always @(posedge clk) begin : modelStep
    logic wrDiv, wrTima, wrTma, wrTac, inc;
    logic [7:0] newTima, newTma;
    if (reset) begin
      mDiv = '0; mPrevDiv = '0; mTima = '0; mTma = '0;
      mTac = '0; mPrevTac = '0; mPrevDivWr = 1'b0; mPending = 1'b0;
    end else begin
      wrDiv  = bus.ff04_ff07 && bus.cpu_wr && (bus.a == 2'd0);
      wrTima = bus.ff04_ff07 && bus.cpu_wr && (bus.a == 2'd1);
      wrTma  = bus.ff04_ff07 && bus.cpu_wr && (bus.a == 2'd2);
      wrTac  = bus.ff04_ff07 && bus.cpu_wr && (bus.a == 2'd3);
`ifdef TIMER_DIV_GLITCH_EN
      inc = (tapOf(mPrevDiv, mPrevTac) && mPrevTac[2]) && !(tapOf(mDiv, mTac) && mTac[2]);
`else
      inc = mPrevTac[2] && mTac[2] && !mPrevDivWr && tapOf(mPrevDiv, mTac) && !tapOf(mDiv, mTac);
`endif
      newTma  = wrTma ? bus.d_in : mTma;
      newTima = mTima;
      if (mPending && edgeCnt == mReloadAt) begin
        newTima  = newTma;
        mPending = 1'b0;
        intQ.push_back(edgeCnt);
      end else if (wrTima) begin
        newTima  = bus.d_in;
        mPending = 1'b0;
      end else if (inc) begin
        if (mTima == 8'hFF) begin
          newTima   = 8'h00;
          mPending  = 1'b1;
          mReloadAt = edgeCnt + RELOAD_DELAY;
        end else begin
          newTima = mTima + 8'd1;
        end
      end
      mPrevDiv   = mDiv;
      mPrevTac   = mTac;
      mPrevDivWr = wrDiv;
      mDiv       = wrDiv ? 16'h0000 : mDiv + 16'd1;
      mTac       = wrTac ? bus.d_in[2:0] : mTac;
      mTima      = newTima;
      mTma       = newTma;
    end
    edgeCnt++;
  end

  // Monitor: pops expected read data whenever the DUT drives the bus, and expected interrupt edges.
  always @(negedge clk) begin
    if (bus.d_oe) begin
      if (rdQ.size() == 0) checkOutput("rd_unexpected_oe", 16'(bus.d_oe), 16'h0);
      else                 checkOutput("rd_data", 16'(bus.d_out), 16'(rdQ.pop_front()));
    end
    if (bus.int_timer) begin
      intSeen++;
      if (intQ.size() == 0) checkOutput("int_unexpected", 16'(bus.int_timer), 16'h0);
      else                  checkOutput("int_edge", 16'(edgeCnt - 1), 16'(intQ.pop_front()));
    end
    if (edgeCnt % 256 == 0) checkOutput("div_apu", 16'(bus.div_apu), 16'(mDiv[12]));
  end

  task automatic applyStimulus(input logic sel, input logic [1:0] addr, input logic wr,
                               input logic rd, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.ff04_ff07 = sel;
    bus.a         = addr;
    bus.cpu_wr    = wr;
    bus.cpu_rd    = rd;
    bus.d_in      = data;
    if (sel && rd) rdQ.push_back(modelRead(addr));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.ff04_ff07 = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_rd    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Idle until the next driven clk sits 'offset' clks before the pending reload edge.
  task automatic waitPending(input int offset);
    int budget = 0;
    while (!(mPending && (mReloadAt - (edgeCnt + 1)) == offset) && budget < 64) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
      budget++;
    end
    checkOutput("wait_overflow_timeout", 16'(budget >= 64), 16'h0);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int intBefore;
    int budget;
    bus.ff04_ff07 = 1'b0;
    bus.a         = 2'd0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.d_in      = 8'h00;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_int_timer", 16'(bus.int_timer), 16'h0);
    checkOutput("rst_d_oe", 16'(bus.d_oe), 16'h0);
    checkOutput("rst_d_out", 16'(bus.d_out), 16'h0);
    checkOutput("rst_div_apu", 16'(bus.div_apu), 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 1'b0, 1'b1, 8'h00);

    $display("[TB] TIMA counting with TAC=101");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 8'h05);
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);

    $display("[TB] overflow and reload");
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 8'hF0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
    intBefore = intSeen;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("ovf_int_count", 16'(intSeen - intBefore), 16'd1);

    $display("[TB] TIMA write cancels pending reload");
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
    waitPending(RELOAD_DELAY - 2);
    intBefore = intSeen;
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'h33);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("cancel_int_count", 16'(intSeen - intBefore), 16'd0);

    $display("[TB] TMA write in reload clk");
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
    waitPending(0);
    intBefore = intSeen;
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("tma_reload_int_count", 16'(intSeen - intBefore), 16'd1);

    $display("[TB] reset during pending reload");
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
    waitPending(2);
    intBefore = intSeen;
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    checkOutput("reset_abort_int_count", 16'(intSeen - intBefore), 16'd0);

    $display("[TB] DIV write with tap bit 9 high");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 8'h04);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 8'h10);
    budget = 0;
    while (mDiv + 16'd1 != 16'h0210 && budget < 2000) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
      budget++;
    end
    checkOutput("wait_div_timeout", 16'(budget >= 2000), 16'h0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);

    $display("[TB] TAC readback and deselected read");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("tac_d_oe", 16'(bus.d_oe), 16'd1);
    checkOutput("tac_d_out", 16'(bus.d_out), 16'hFA);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("nosel_d_oe", 16'(bus.d_oe), 16'd0);
    checkOutput("nosel_d_out", 16'(bus.d_out), 16'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 6000; i++) begin
      int r;
      int r2;
      logic sel;
      logic [7:0] data;
      r   = int'($urandom_range(0, 999));
      r2  = int'($urandom_range(0, 99));
      sel = ($urandom_range(0, 9) != 0);
      if (r < 2) begin
        doReset();
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 8'h05);
      end else if (r < 400) begin
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
      end else if (r < 700) begin
        applyStimulus(sel, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 8'h00);
      end else if (r2 < 3) begin
        applyStimulus(sel, 2'd0, 1'b1, 1'b0, 8'($urandom));
      end else if (r2 < 50) begin
        data = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom);
        applyStimulus(sel, 2'd1, 1'b1, 1'b0, data);
      end else if (r2 < 80) begin
        applyStimulus(sel, 2'd2, 1'b1, 1'b0, 8'($urandom));
      end else begin
        data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(5, 6));
        applyStimulus(sel, 2'd3, 1'b1, 1'b0, data);
      end
    end

    $display("[TB] long free run for DIV upper bits");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 8'h07);
    for (int i = 0; i < 4500; i++) begin
      if (i % 97 == 0) applyStimulus(1'b1, 2'($urandom_range(0, 1)), 1'b0, 1'b1, 8'h00);
      else             applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    end

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("rdq_drained", 16'(rdQ.size()), 16'd0);
    checkOutput("intq_drained", 16'(intQ.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
